// File: rtl/r32_mem_responder.sv
// Memory-side endpoint of the R32 request/response interface: word-addressed RAM,
// fixed-latency read pipeline and an in-order response FIFO with credit-based flow control.
module r32_mem_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m_address,
  input  logic [31:0] m_data,
  input  logic        m_write,
  input  logic        m_valid,
  output logic        m_ready,
  output logic [31:0] s_data,
  output logic        s_valid,
  input  logic        s_ready
);

  localparam int WORDS = 1 << ADDR_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W:0]   PTR_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [31:0]           ram [WORDS];
  logic [ADDR_WIDTH-1:0] index;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  pop;
  logic                  fifo_wr;
  logic [31:0]           fifo_wdata;
  logic [31:0]           fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic                  unused_addr_bits;

  // Handshake: a beat transfers on a rising edge where valid && ready are both high;
  // the sender holds its payload stable while valid && !ready.
  assign rd_accept = m_valid && m_ready && !m_write;
  assign wr_accept = m_valid && m_ready && m_write;
  assign pop       = s_valid && s_ready;

  // Byte lane and upper address bits are dropped, so addresses alias on the RAM size.
  assign index            = m_address[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{m_address[31:ADDR_WIDTH+2], m_address[1:0]};

  always_ff @(posedge clock) begin
    if (wr_accept) ram[index] <= m_data;
  end

  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign fifo_wr    = rd_accept;
      assign fifo_wdata = ram[index];
    end else begin : g_pipe
      localparam int STAGES = READ_LATENCY - 1;
      logic [31:0]       pipe_data [STAGES];
      logic [STAGES-1:0] pipe_valid;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          pipe_valid <= '0;
          for (int i = 0; i < STAGES; i++) pipe_data[i] <= '0;
        end else begin
          pipe_valid[0] <= rd_accept;
          pipe_data[0]  <= ram[index];
          for (int i = 1; i < STAGES; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_data[i]  <= pipe_data[i-1];
          end
        end
      end

      assign fifo_wr    = pipe_valid[STAGES-1];
      assign fifo_wdata = pipe_data[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (fifo_wr) fifo_mem[wr_ptr[PTR_W-1:0]] <= fifo_wdata;
  end

  assign s_valid = (wr_ptr != rd_ptr);
  assign s_data  = s_valid ? fifo_mem[rd_ptr[PTR_W-1:0]] : '0;

  // Outstanding count covers pipeline plus FIFO, so a credit is held from accept to pop.
  always_comb begin
    count_next = count;
    if (rd_accept && !pop)      count_next = count + CNT_ONE;
    else if (!rd_accept && pop) count_next = count - CNT_ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      m_ready <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_next;
      m_ready <= (count_next < CNT_FULL);
    end
  end

endmodule

// File: tb/tb_r32_mem_responder.sv
// Bench for r32_mem_responder: directed scenarios followed by randomized traffic,
// all responses checked against a queue-based reference of the memory and read ordering.
module tb_r32_mem_responder;

  localparam int ADDR_WIDTH   = 10;
  localparam int READ_LATENCY = 2;
  localparam int FIFO_DEPTH   = 4;
  localparam int WORDS        = 1 << ADDR_WIDTH;

  logic        clock;
  logic        reset;
  logic [31:0] m_address;
  logic [31:0] m_data;
  logic        m_write;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  r32_mem_responder #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .m_address(m_address),
    .m_data   (m_data),
    .m_write  (m_write),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready)
  );

  // clock/reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model and scoreboard
  logic [31:0] model_mem [WORDS];
  logic [31:0] exp_q[$];
  int          vis_q[$];
  logic [31:0] got_q[$];
  logic        exp_ready = 1'b0;
  int          cyc = 0;
  int          beats = 0;
  int          run_len = 0;
  int          max_run = 0;
  int          stall_cycles = 0;
  logic        rand_sready = 1'b0;

  always @(posedge clock) cyc++;

  // Inputs change just after a rising edge, so at the falling edge they and the
  // outputs are settled and describe exactly what the next rising edge will do.
  always @(negedge clock) begin
    int unsigned idx;
    logic        exp_sv;
    if (reset) begin
      check("rst_m_ready", 32'(m_ready), 32'd0);
      check("rst_s_valid", 32'(s_valid), 32'd0);
      check("rst_s_data", s_data, 32'd0);
      exp_q.delete();
      vis_q.delete();
      exp_ready = 1'b0;
      run_len   = 0;
    end else begin
      check("m_ready", 32'(m_ready), 32'(exp_ready));
      exp_sv = (exp_q.size() > 0) && (vis_q[0] <= cyc);
      check("s_valid", 32'(s_valid), 32'(exp_sv));
      if (exp_sv) check("s_data", s_data, exp_q[0]);
      if (s_valid && s_ready) begin
        check("pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(vis_q.pop_front());
        end
        got_q.push_back(s_data);
        beats++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (m_valid && m_ready) begin
        idx = (m_address >> 2) % WORDS;
        if (m_write) begin
          model_mem[idx] = m_data;
        end else begin
          exp_q.push_back(model_mem[idx]);
          vis_q.push_back(cyc + READ_LATENCY);
          check("outstanding_max", 32'(exp_q.size() <= FIFO_DEPTH), 32'd1);
        end
      end
      exp_ready = (exp_q.size() < FIFO_DEPTH);
    end
  end

  // driver tasks: called #1 after a rising edge, return #1 after the accepting edge
  task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int   waits;
    logic timed_out;
    waits     = 0;
    timed_out = 1'b0;
    m_valid   = 1'b1;
    m_write   = wr;
    m_address = addr;
    m_data    = data;
    forever begin
      @(negedge clock);
      if (m_ready) break;
      waits++;
      stall_cycles++;
      if (waits > 100) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
      if (rand_sready) s_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clock);
    #1;
    m_valid = 1'b0;
    check("req_timeout", 32'(timed_out), 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int          b0;
    int          s0;
    int          k;
    int          gap;
    logic [31:0] addr;
    reset     = 1'b1;
    m_valid   = 1'b0;
    m_write   = 1'b0;
    m_address = '0;
    m_data    = '0;
    s_ready   = 1'b0;

    // 1: reset behaviour, both at power-up and as a mid-cycle pulse
    wait_cycles(3);
    check("t1_in_reset_m_ready", 32'(m_ready), 32'd0);
    reset = 1'b0;
    check("t1_release_m_ready_low", 32'(m_ready), 32'd0);
    wait_cycles(1);
    check("t1_m_ready_after_edge", 32'(m_ready), 32'd1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("t1_pulse_m_ready", 32'(m_ready), 32'd0);
    check("t1_pulse_s_valid", 32'(s_valid), 32'd0);
    wait_cycles(1);
    reset = 1'b0;
    check("t1_pulse_release_low", 32'(m_ready), 32'd0);
    wait_cycles(1);
    check("t1_pulse_m_ready_up", 32'(m_ready), 32'd1);

    // preload the low words so every later read has a known model value
    s_ready = 1'b1;
    for (int w = 0; w < 64; w++) req(1'b1, 32'(w * 4), $urandom());

    // 2: write then read-after-write, exact latency, single beat
    b0 = beats;
    req(1'b1, 32'h10, 32'hDEADBEEF);
    req(1'b0, 32'h10, 32'h0);
    check("t2_not_yet_valid", 32'(s_valid), 32'd0);
    wait_cycles(1);
    check("t2_valid", 32'(s_valid), 32'd1);
    check("t2_data", s_data, 32'hDEADBEEF);
    wait_cycles(1);
    check("t2_one_beat_valid", 32'(s_valid), 32'd0);
    check("t2_one_beat_count", 32'(beats - b0), 32'd1);

    // 3: backpressure fills the credit window
    s_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      m_valid   = (k < 6);
      m_write   = 1'b0;
      m_address = 32'(k * 4);
      @(negedge clock);
      if (m_valid && m_ready) k++;
      @(posedge clock);
      #1;
    end
    m_valid = 1'b0;
    check("t3_accepted", 32'(k), 32'd4);
    check("t3_m_ready_low", 32'(m_ready), 32'd0);
    check("t3_s_valid", 32'(s_valid), 32'd1);
    check("t3_head_held", s_data, model_mem[0]);
    b0 = beats;
    s_ready = 1'b1;
    wait_cycles(8);
    check("t3_beats", 32'(beats - b0), 32'd4);
    check("t3_m_ready_back", 32'(m_ready), 32'd1);

    // 4: back-to-back reads at full throughput
    s0      = stall_cycles;
    b0      = beats;
    max_run = 0;
    for (int i = 0; i < 8; i++) req(1'b0, 32'(i * 4), 32'h0);
    wait_cycles(4);
    check("t4_no_stall", 32'(stall_cycles - s0), 32'd0);
    check("t4_beats", 32'(beats - b0), 32'd8);
    check("t4_consecutive", 32'(max_run >= 8), 32'd1);

    // 5: address aliasing
    req(1'b1, 32'h0, 32'h11111111);
    req(1'b0, 32'h3, 32'h0);
    req(1'b0, 32'h1000, 32'h0);
    wait_cycles(4);
    check("t5_alias_low", got_q[got_q.size()-2], 32'h11111111);
    check("t5_alias_high", got_q[got_q.size()-1], 32'h11111111);

    // 6: reset with reads in flight drops them; RAM contents survive
    req(1'b1, 32'h40, 32'hCAFEF00D);
    req(1'b0, 32'h0, 32'h0);
    req(1'b0, 32'h4, 32'h0);
    reset = 1'b1;
    #1;
    check("t6_reset_s_valid", 32'(s_valid), 32'd0);
    b0 = beats;
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(6);
    check("t6_no_stale_beats", 32'(beats - b0), 32'd0);
    req(1'b0, 32'h40, 32'h0);
    wait_cycles(4);
    check("t6_one_beat", 32'(beats - b0), 32'd1);
    check("t6_ram_kept", got_q[got_q.size()-1], 32'hCAFEF00D);

    // randomized traffic with random backpressure and aliased upper address bits
    rand_sready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clock);
        #1;
        s_ready = ($urandom_range(0, 3) != 0);
      end
      addr = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63) * 4)
             | 32'($urandom_range(0, 3));
      req(($urandom_range(0, 3) == 0), addr, $urandom());
    end
    rand_sready = 1'b0;
    s_ready     = 1'b1;
    wait_cycles(12);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_s_valid", 32'(s_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
